weight_fetch_sequencer: RTL and testbench
=========================================

// Module: weight_fetch_sequencer
// PURPOSE
//  Sequences one neuron's weight memory: per input beat it drives the read address, pairs the
//  returned weights with the input data, and emits an aligned {x, w, last} stream to the MAC.
//  Also arbitrates runtime weight reload (cfg bus) against inference, so weights change only
//  between passes. One instance sits beside each neuron's weight memory, between the layer
//  input stream and the neuron MAC.
// PARAMETERS
//  numWeight      784  total weights stored for this neuron
//  neuronNo       0    this neuron's index; cfg writes tagged with another index are ignored
//  addressWidth   10   memory address width
//  dataWidth      16   width of one weight / one input element
//  input_channels 1    parallel lanes per beat; DEPTH = numWeight/input_channels beats per pass
//  neuronIdWidth  8    width of cfg_neuron
// PORTS
//  clk         in   1                     clock, rising edge
//  rst         in   1                     reset, asynchronous, active-high
//  in_valid    in   1                     input beat valid
//  in_ready    out  1                     input beat accepted when in_valid & in_ready
//  in_data     in   input_channels*dataWidth  input activations for this beat
//  cfg_valid   in   1                     weight-write request
//  cfg_ready   out  1                     write accepted when cfg_valid & cfg_ready
//  cfg_neuron  in   neuronIdWidth         target neuron index
//  cfg_addr    in   addressWidth          target weight address
//  cfg_data    in   dataWidth             weight value
//  mem_wen     out  1                     memory write enable
//  mem_wadd    out  addressWidth          memory write address
//  mem_win     out  dataWidth             memory write data
//  mem_radd    out  addressWidth          memory read address (memory read is combinational)
//  mem_wout    in   input_channels*dataWidth  weights returned for mem_radd
//  out_valid   out  1                     output beat valid
//  out_ready   in   1                     downstream accept
//  out_x       out  input_channels*dataWidth  registered input data
//  out_w       out  input_channels*dataWidth  weights for that beat
//  out_last    out  1                     final beat of a pass (beat index DEPTH-1)
//  busy        out  1                     high while a pass is in progress (beat index != 0 or out_valid)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, beat counter=0, out_valid=0, out_last=0, out_x=0,
//    out_w=0, mem_radd=0, mem_wen=0, mem_wadd=0, mem_win=0, busy=0. In-flight beat is dropped;
//    a partially written cfg burst is not rolled back.
//  - States: IDLE (counter=0, output reg empty), RUN (counter in 1..DEPTH-1 or output reg full).
//  - mem_radd = registered beat counter; out_w = mem_wout sampled with the same edge that loads
//    out_x, so out_x/out_w/out_last always refer to the same address. Latency in->out: 1 cycle.
//  - Single output register: in_ready = ~cfg_grant & (~out_valid | out_ready). Full throughput
//    (one beat/cycle) when out_ready held high. out_* held stable while out_valid & ~out_ready.
//  - Counter increments on each accepted in beat; at DEPTH-1 the beat gets out_last=1 and the
//    counter wraps to 0. Back-to-back passes allowed with no bubble.
//  - cfg_ready = 1 only when counter==0 AND (out_valid==0 OR (out_valid & out_last & out_ready)).
//  - cfg_grant = cfg_valid & cfg_ready. Simultaneous cfg_valid and in_valid at a pass boundary:
//    cfg wins, in_ready=0 that cycle; input waits until cfg_valid drops.
//  - Accepted cfg with cfg_neuron==neuronNo: next cycle mem_wen=1, mem_wadd=cfg_addr,
//    mem_win=cfg_data for exactly one cycle. Mismatched neuron: accepted (cfg_ready honoured,
//    bus not stalled) but mem_wen stays 0. cfg_addr >= numWeight: accepted, write suppressed.
//  - A write issued in cycle t is visible to a read address presented in cycle t+1 or later;
//    the first beat after a write burst is never issued in the same cycle as mem_wen.
//  - busy=0 exactly when state IDLE.
// STRUCTURE
//  - Shared package: DEPTH computation, beat-counter width ($clog2(DEPTH)), neuron-id width.
//  - One natural sub-module: weight_cfg_filter (neuron-id/address match + one-cycle write
//    register driving mem_wen/mem_wadd/mem_win). Counter/handshake logic stays in top.
// TESTING
//  1 numWeight=4, ch=1, mem preloaded 1..4; 4 beats x=10,20,30,40, out_ready=1 ->
//    out_w=1,2,3,4 paired with x, out_last only on 4th beat, 1-cycle latency, busy drops after.
//  2 Same, out_ready low 3 cycles on beat 2 -> out_x=20,out_w=2 held stable, in_ready=0, no loss.
//  3 cfg neuron=neuronNo addr=2 data=99 while idle -> mem_wen pulse 1 cycle; next pass beat 3
//    out_w=99. cfg with neuron=neuronNo+1 -> cfg_ready=1, mem_wen never asserted.
//  4 cfg_valid raised mid-pass (after beat 2) -> cfg_ready=0 until last beat handshakes;
//    cfg and in_valid both high at boundary -> write first, in_ready=0 that cycle.
//  5 ch=2, numWeight=8 -> DEPTH=4, lane1 weights from radd, lane0 from radd+4; last on 4th beat.
//  6 rst pulsed asynchronously mid-pass (beat 2, out_valid=1) -> out_valid=0 immediately, next
//    pass starts at radd=0 with out_last on its DEPTH-th beat.

Source files
------------

// File: rtl/weight_fetch_sequencer_pkg.sv
// Shared types and sizing helpers for the weight fetch sequencer and its sub-blocks.
package weight_fetch_sequencer_pkg;

  localparam int unsigned NEURON_ID_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Beats per pass: each beat carries one weight per lane.
  function automatic int unsigned calc_depth(input int unsigned num_weight,
                                             input int unsigned channels);
    return num_weight / channels;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/weight_fetch_sequencer_if.sv
// Bundle of the input, cfg, memory and output streams around one weight fetch sequencer.
interface weight_fetch_sequencer_if
  import weight_fetch_sequencer_pkg::*;
#(
  parameter int unsigned CH   = 1,
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 10,
  parameter int unsigned NIDW = NEURON_ID_WIDTH
) ();

  // Every stream transfers on a rising edge where valid & ready are both high;
  // a producer holds its payload stable while valid is high and ready is low.
  logic               in_valid;
  logic               in_ready;
  logic [CH*DW-1:0]   in_data;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [NIDW-1:0]    cfg_neuron;
  logic [AW-1:0]      cfg_addr;
  logic [DW-1:0]      cfg_data;

  logic               mem_wen;
  logic [AW-1:0]      mem_wadd;
  logic [DW-1:0]      mem_win;
  logic [AW-1:0]      mem_radd;
  logic [CH*DW-1:0]   mem_wout;

  logic               out_valid;
  logic               out_ready;
  logic [CH*DW-1:0]   out_x;
  logic [CH*DW-1:0]   out_w;
  logic               out_last;

  logic               busy;
  seq_state_e         state;

  modport master (
    input  in_valid, in_data, cfg_valid, cfg_neuron, cfg_addr, cfg_data, mem_wout, out_ready,
    output in_ready, cfg_ready, mem_wen, mem_wadd, mem_win, mem_radd,
           out_valid, out_x, out_w, out_last, busy, state
  );

  modport slave (
    output in_valid, in_data, cfg_valid, cfg_neuron, cfg_addr, cfg_data, mem_wout, out_ready,
    input  in_ready, cfg_ready, mem_wen, mem_wadd, mem_win, mem_radd,
           out_valid, out_x, out_w, out_last, busy, state
  );

endinterface

// File: rtl/weight_fetch_sequencer_cfg_filter.sv
// Filters accepted cfg writes by neuron id and address range, and registers the surviving
// write into a single-cycle memory write strobe.
module weight_cfg_filter
  import weight_fetch_sequencer_pkg::*;
#(
  parameter int unsigned NUM_WEIGHT = 784,
  parameter int unsigned NEURON_NO  = 0,
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 16,
  parameter int unsigned NIDW       = NEURON_ID_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_fire_i,
  input  logic [NIDW-1:0] cfg_neuron_i,
  input  logic [AW-1:0]   cfg_addr_i,
  input  logic [DW-1:0]   cfg_data_i,
  output logic            mem_wen_o,
  output logic [AW-1:0]   mem_wadd_o,
  output logic [DW-1:0]   mem_win_o
);

  localparam logic [NIDW-1:0] NEURON_ID = NIDW'(NEURON_NO);

  logic          hit;
  logic          wen_q, wen_d;
  logic [AW-1:0] wadd_q, wadd_d;
  logic [DW-1:0] win_q, win_d;

  // Writes for other neurons or beyond the stored range are consumed silently.
  assign hit = cfg_fire_i && (cfg_neuron_i == NEURON_ID) && (32'(cfg_addr_i) < NUM_WEIGHT);

  always_comb begin
    wen_d  = hit;
    wadd_d = wadd_q;
    win_d  = win_q;
    if (hit) begin
      wadd_d = cfg_addr_i;
      win_d  = cfg_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q  <= 1'b0;
      wadd_q <= '0;
      win_q  <= '0;
    end else begin
      wen_q  <= wen_d;
      wadd_q <= wadd_d;
      win_q  <= win_d;
    end
  end

  assign mem_wen_o  = wen_q;
  assign mem_wadd_o = wadd_q;
  assign mem_win_o  = win_q;

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Walks one neuron's weight memory once per pass, pairing each input beat with its weights,
// and lets cfg reloads in only between passes.
module weight_fetch_sequencer
  import weight_fetch_sequencer_pkg::*;
#(
  parameter int unsigned numWeight      = 784,
  parameter int unsigned neuronNo       = 0,
  parameter int unsigned addressWidth   = 10,
  parameter int unsigned dataWidth      = 16,
  parameter int unsigned input_channels = 1,
  parameter int unsigned neuronIdWidth  = NEURON_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  weight_fetch_sequencer_if.master bus
);

  localparam int unsigned DEPTH = calc_depth(numWeight, input_channels);
  localparam int unsigned CW    = cnt_width(DEPTH);
  localparam int unsigned LW    = input_channels * dataWidth;
  localparam logic [CW-1:0] LAST_BEAT = CW'(DEPTH - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [LW-1:0] out_x_q, out_x_d;
  logic [LW-1:0] out_w_q, out_w_d;

  logic cfg_ready, cfg_grant, in_ready, in_fire, wen;

  // Reload is only legal at a pass boundary: counter back at 0 and the last beat leaving.
  assign cfg_ready = (cnt_q == '0) && (!out_valid_q || (out_last_q && bus.out_ready));
  assign cfg_grant = bus.cfg_valid && cfg_ready;
  // Holding input off while mem_wen is high keeps a fresh write from racing the next read.
  assign in_ready  = !cfg_grant && !wen && (!out_valid_q || bus.out_ready);
  assign in_fire   = bus.in_valid && in_ready;

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_x_d     = out_x_q;
    out_w_d     = out_w_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_last_d  = (cnt_q == LAST_BEAT);
      out_x_d     = bus.in_data;
      out_w_d     = bus.mem_wout;
      cnt_d       = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CW'(1);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    state_d = ((cnt_d != '0) || out_valid_d) ? ST_RUN : ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_x_q     <= '0;
      out_w_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_x_q     <= out_x_d;
      out_w_q     <= out_w_d;
    end
  end

  weight_cfg_filter #(
    .NUM_WEIGHT (numWeight),
    .NEURON_NO  (neuronNo),
    .AW         (addressWidth),
    .DW         (dataWidth),
    .NIDW       (neuronIdWidth)
  ) u_cfg_filter (
    .clk          (clk),
    .rst          (rst),
    .cfg_fire_i   (cfg_grant),
    .cfg_neuron_i (bus.cfg_neuron),
    .cfg_addr_i   (bus.cfg_addr),
    .cfg_data_i   (bus.cfg_data),
    .mem_wen_o    (wen),
    .mem_wadd_o   (bus.mem_wadd),
    .mem_win_o    (bus.mem_win)
  );

  assign bus.mem_wen   = wen;
  assign bus.mem_radd  = addressWidth'(cnt_q);
  assign bus.in_ready  = in_ready;
  assign bus.cfg_ready = cfg_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_w     = out_w_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench: a single-lane 4-weight instance and a two-lane 8-weight instance, each
// with a small behavioural weight memory and an in-order expected-beat scoreboard.
module tb_weight_fetch_sequencer;
  import weight_fetch_sequencer_pkg::*;

  localparam int unsigned WA = 1 + 16 + 16;
  localparam int unsigned WB = 1 + 32 + 32;

  logic clk;
  logic rst;
  logic mem_init;

  int checks = 0;
  int errors = 0;
  int wen_a_cnt = 0;

  logic [WA-1:0] exp_a_q[$];
  logic [WB-1:0] exp_b_q[$];

  logic [15:0] mem_a [0:3];
  logic [15:0] mem_b [0:7];

  weight_fetch_sequencer_if #(.CH(1), .DW(16), .AW(10), .NIDW(8)) ifa ();
  weight_fetch_sequencer_if #(.CH(2), .DW(16), .AW(10), .NIDW(8)) ifb ();

  weight_fetch_sequencer #(
    .numWeight(4), .neuronNo(0), .addressWidth(10), .dataWidth(16),
    .input_channels(1), .neuronIdWidth(8)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));

  weight_fetch_sequencer #(
    .numWeight(8), .neuronNo(0), .addressWidth(10), .dataWidth(16),
    .input_channels(2), .neuronIdWidth(8)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- memory models ----------------
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4; i++) mem_a[i] <= 16'(i + 1);
    end else if (ifa.mem_wen && ifa.mem_wadd < 10'd4) begin
      mem_a[ifa.mem_wadd[1:0]] <= ifa.mem_win;
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem_b[i] <= 16'(i + 1);
    end else if (ifb.mem_wen && ifb.mem_wadd < 10'd8) begin
      mem_b[ifb.mem_wadd[2:0]] <= ifb.mem_win;
    end
  end

  always_comb begin
    ifa.mem_wout = '0;
    if (ifa.mem_radd < 10'd4) ifa.mem_wout = mem_a[ifa.mem_radd[1:0]];
  end

  // Lane 1 (upper) reads radd, lane 0 (lower) reads radd + DEPTH.
  always_comb begin
    ifb.mem_wout = '0;
    if (ifb.mem_radd < 10'd4)
      ifb.mem_wout = {mem_b[ifb.mem_radd[2:0]], mem_b[ifb.mem_radd[2:0] + 3'd4]};
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifa.mem_wen) wen_a_cnt++;
  end

  always @(negedge clk) begin
    logic [WA-1:0] e;
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      if (exp_a_q.size() == 0) begin
        chk("a_unexpected_beat", 128'({ifa.out_last, ifa.out_x, ifa.out_w}), 128'hDEAD);
      end else begin
        e = exp_a_q.pop_front();
        chk("a_beat", 128'({ifa.out_last, ifa.out_x, ifa.out_w}), 128'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [WB-1:0] e;
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (exp_b_q.size() == 0) begin
        chk("b_unexpected_beat", 128'({ifb.out_last, ifb.out_x, ifb.out_w}), 128'hDEAD);
      end else begin
        e = exp_b_q.pop_front();
        chk("b_beat", 128'({ifb.out_last, ifb.out_x, ifb.out_w}), 128'(e));
      end
    end
  end

  // ---------------- drivers (all input changes at posedge+1) ----------------
  task automatic send_a(input logic [15:0] x, input logic [15:0] ew, input logic el);
    int n;
    bit acc;
    exp_a_q.push_back({el, x, ew});
    ifa.in_valid = 1'b1;
    ifa.in_data  = x;
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = ifa.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 40) begin
        chk("a_in_timeout", 128'(n), 128'(0));
        break;
      end
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] x, input logic [31:0] ew, input logic el);
    int n;
    bit acc;
    exp_b_q.push_back({el, x, ew});
    ifb.in_valid = 1'b1;
    ifb.in_data  = x;
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = ifb.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 40) begin
        chk("b_in_timeout", 128'(n), 128'(0));
        break;
      end
    end
    ifb.in_valid = 1'b0;
  endtask

  task automatic cfg_a(input logic [7:0] nid, input logic [9:0] addr, input logic [15:0] data,
                       output int stalls);
    bit acc;
    ifa.cfg_valid  = 1'b1;
    ifa.cfg_neuron = nid;
    ifa.cfg_addr   = addr;
    ifa.cfg_data   = data;
    stalls = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = ifa.cfg_ready;
      @(posedge clk);
      #1;
      if (!acc) stalls++;
      if (!acc && stalls > 40) begin
        chk("a_cfg_timeout", 128'(stalls), 128'(0));
        break;
      end
    end
    ifa.cfg_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int wen_before;
    bit found;

    rst = 1'b1;
    mem_init = 1'b1;
    ifa.in_valid = 1'b0;  ifa.in_data = '0;   ifa.out_ready = 1'b1;
    ifa.cfg_valid = 1'b0; ifa.cfg_neuron = '0; ifa.cfg_addr = '0; ifa.cfg_data = '0;
    ifb.in_valid = 1'b0;  ifb.in_data = '0;   ifb.out_ready = 1'b1;
    ifb.cfg_valid = 1'b0; ifb.cfg_neuron = '0; ifb.cfg_addr = '0; ifb.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_init = 1'b0;

    // Reset state
    chk("rst_out_valid", 128'(ifa.out_valid), 128'(0));
    chk("rst_out_last",  128'(ifa.out_last),  128'(0));
    chk("rst_busy",      128'(ifa.busy),      128'(0));
    chk("rst_radd",      128'(ifa.mem_radd),  128'(0));
    chk("rst_wen",       128'(ifa.mem_wen),   128'(0));
    chk("rst_wadd",      128'(ifa.mem_wadd),  128'(0));
    chk("rst_win",       128'(ifa.mem_win),   128'(0));
    chk("rst_out_x",     128'(ifa.out_x),     128'(0));
    chk("rst_out_w",     128'(ifa.out_w),     128'(0));
    chk("rst_state",     128'(ifa.state),     128'(ST_IDLE));
    chk("rst_in_ready",  128'(ifa.in_ready),  128'(1));
    chk("rst_cfg_ready", 128'(ifa.cfg_ready), 128'(1));
    chk("rst_b_busy",    128'(ifb.busy),      128'(0));

    // 1: one full pass at full throughput
    send_a(16'd10, 16'd1, 1'b0);
    chk("t1_latency_valid", 128'(ifa.out_valid), 128'(1));
    chk("t1_latency_x",     128'(ifa.out_x),     128'(10));
    chk("t1_busy_mid",      128'(ifa.busy),      128'(1));
    chk("t1_radd_mid",      128'(ifa.mem_radd),  128'(1));
    send_a(16'd20, 16'd2, 1'b0);
    send_a(16'd30, 16'd3, 1'b0);
    send_a(16'd40, 16'd4, 1'b1);
    chk("t1_last_flag", 128'(ifa.out_last), 128'(1));
    chk("t1_busy_last", 128'(ifa.busy),     128'(1));
    idle_cycles(1);
    chk("t1_busy_after",  128'(ifa.busy),      128'(0));
    chk("t1_valid_after", 128'(ifa.out_valid), 128'(0));
    chk("t1_radd_after",  128'(ifa.mem_radd),  128'(0));

    // 2: backpressure on beat 2 for three cycles
    fork
      begin
        send_a(16'd10, 16'd1, 1'b0);
        send_a(16'd20, 16'd2, 1'b0);
        send_a(16'd30, 16'd3, 1'b0);
        send_a(16'd40, 16'd4, 1'b1);
      end
      begin
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
          @(posedge clk);
          #1;
          found = ifa.out_valid && (ifa.out_x == 16'd20);
        end
        chk("t2_found_beat2", 128'(found), 128'(1));
        ifa.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t2_hold_valid", 128'(ifa.out_valid), 128'(1));
          chk("t2_hold_x",     128'(ifa.out_x),     128'(20));
          chk("t2_hold_w",     128'(ifa.out_w),     128'(2));
          chk("t2_in_ready",   128'(ifa.in_ready),  128'(0));
          @(posedge clk);
          #1;
        end
        ifa.out_ready = 1'b1;
      end
    join
    idle_cycles(2);

    // 3: matching write while idle, then writes that must be dropped
    wen_before = wen_a_cnt;
    cfg_a(8'd0, 10'd2, 16'd99, st);
    chk("t3_cfg_stall", 128'(st),           128'(0));
    chk("t3_wen",       128'(ifa.mem_wen),  128'(1));
    chk("t3_wadd",      128'(ifa.mem_wadd), 128'(2));
    chk("t3_win",       128'(ifa.mem_win),  128'(99));
    idle_cycles(1);
    chk("t3_wen_pulse", 128'(ifa.mem_wen),  128'(0));
    chk("t3_wen_count", 128'(wen_a_cnt - wen_before), 128'(1));
    send_a(16'd11, 16'd1,  1'b0);
    send_a(16'd21, 16'd2,  1'b0);
    send_a(16'd31, 16'd99, 1'b0);
    send_a(16'd41, 16'd4,  1'b1);
    idle_cycles(2);
    wen_before = wen_a_cnt;
    cfg_a(8'd1, 10'd1, 16'd55, st);
    chk("t3_other_neuron_stall", 128'(st), 128'(0));
    idle_cycles(2);
    cfg_a(8'd0, 10'd5, 16'd66, st);
    chk("t3_oob_addr_stall", 128'(st), 128'(0));
    idle_cycles(2);
    chk("t3_no_wen", 128'(wen_a_cnt - wen_before), 128'(0));

    // 4: cfg raised mid-pass, granted at the boundary ahead of the next pass
    fork
      begin
        send_a(16'd50,  16'd1,  1'b0);
        send_a(16'd60,  16'd2,  1'b0);
        send_a(16'd70,  16'd99, 1'b0);
        send_a(16'd80,  16'd4,  1'b1);
        send_a(16'd90,  16'd7,  1'b0);
        send_a(16'd100, 16'd2,  1'b0);
        send_a(16'd110, 16'd99, 1'b0);
        send_a(16'd120, 16'd4,  1'b1);
      end
      begin
        bit acc;
        int stalls;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
          @(posedge clk);
          #1;
          found = ifa.out_valid && (ifa.out_x == 16'd60);
        end
        chk("t4_found_beat2", 128'(found), 128'(1));
        ifa.cfg_valid  = 1'b1;
        ifa.cfg_neuron = 8'd0;
        ifa.cfg_addr   = 10'd0;
        ifa.cfg_data   = 16'd7;
        acc = 1'b0;
        stalls = 0;
        while (!acc && stalls < 40) begin
          @(negedge clk);
          acc = ifa.cfg_ready;
          if (acc) begin
            chk("t4_boundary_in_ready", 128'(ifa.in_ready), 128'(0));
            chk("t4_boundary_last",     128'(ifa.out_last), 128'(1));
          end
          @(posedge clk);
          #1;
          if (!acc) stalls++;
        end
        ifa.cfg_valid = 1'b0;
        chk("t4_cfg_stalls", 128'(stalls), 128'(2));
        chk("t4_wen",        128'(ifa.mem_wen), 128'(1));
      end
    join
    idle_cycles(2);
    chk("t4_busy_after", 128'(ifa.busy), 128'(0));

    // 5: two lanes, DEPTH 4
    send_b(32'h000A_000B, 32'h0001_0005, 1'b0);
    chk("t5_radd_mid", 128'(ifb.mem_radd), 128'(1));
    send_b(32'h0014_0015, 32'h0002_0006, 1'b0);
    send_b(32'h001E_001F, 32'h0003_0007, 1'b0);
    send_b(32'h0028_0029, 32'h0004_0008, 1'b1);
    chk("t5_last", 128'(ifb.out_last), 128'(1));
    idle_cycles(2);
    chk("t5_busy_after", 128'(ifb.busy), 128'(0));

    // 6: asynchronous reset with beat 2 in the output register
    send_a(16'd10, 16'd7, 1'b0);
    send_a(16'd20, 16'd2, 1'b0);
    chk("t6_pre_valid", 128'(ifa.out_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 128'(ifa.out_valid), 128'(0));
    chk("t6_rst_busy",  128'(ifa.busy),      128'(0));
    chk("t6_rst_radd",  128'(ifa.mem_radd),  128'(0));
    chk("t6_rst_x",     128'(ifa.out_x),     128'(0));
    chk("t6_queue_before_flush", 128'(exp_a_q.size()), 128'(1));
    exp_a_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_a(16'd15, 16'd7,  1'b0);
    send_a(16'd25, 16'd2,  1'b0);
    send_a(16'd35, 16'd99, 1'b0);
    send_a(16'd45, 16'd4,  1'b1);
    chk("t6_last", 128'(ifa.out_last), 128'(1));
    idle_cycles(2);
    chk("t6_busy_after", 128'(ifa.busy), 128'(0));

    chk("end_a_queue_empty", 128'(exp_a_q.size()), 128'(0));
    chk("end_b_queue_empty", 128'(exp_b_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
